// File: rtl/viterbi_decoder_param.sv
// viterbi_decoder_param: parametrised Viterbi decoder with register-exchange survivors and frame drain
module viterbi_decoder_param #(
    parameter int           K      = 3,
    parameter logic [K-1:0] G0     = 3'b111,
    parameter logic [K-1:0] G1     = 3'b101,
    parameter int           SW     = 1,
    parameter int           TB     = 15,
    parameter int           PMW    = 8,
    parameter bit           P_TERM = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2*SW-1:0] i_data,
    input  logic            i_last,
    output logic            i_ready,
    output logic            o_decision,
    output logic            o_valid,
    output logic            o_last
);
    localparam int NS = 1 << (K - 1);
    localparam int SB = K - 1;
    localparam int CW = $clog2(TB);
    localparam logic [SW-1:0] SMAX = '1;
    localparam logic [PMW-1:0] PM_INIT = {2'b01, {(PMW - 2){1'b0}}};

    typedef enum logic {RUN, DRAIN} state_t;

    if (TB < K) begin : g_tb_too_short
        $error("viterbi_decoder_param: TB must be at least K");
    end
    if ((1 << (PMW - 2)) <= 2 * (K - 1) * ((1 << SW) - 1)) begin : g_pmw_too_narrow
        $error("viterbi_decoder_param: PMW too narrow for the metric spread");
    end

    state_t         state;
    logic [PMW-1:0] pm [NS];
    logic [TB-2:0]  path [NS];
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  dc;
    logic [TB-2:0]  dr;

    logic [PMW-1:0] cand0 [NS];
    logic [PMW-1:0] cand1 [NS];
    logic [PMW-1:0] pm_sel [NS];
    logic [TB-1:0]  path_new [NS];
    logic [NS-1:0]  take;
    logic [PMW-1:0] pm_min;
    logic [SB-1:0]  best;
    logic [TB-1:0]  drain_src;
    logic           accept;
    logic           full;

    // predecessor of next state n whose oldest bit is b
    function automatic logic [SB-1:0] pred(input int n, input logic b);
        return SB'((n << 1) | int'(b));
    endfunction

    // distance between the received pair and the pair expected from encoder register r
    function automatic logic [SW:0] branch_metric(input logic [K-1:0] r, input logic [2*SW-1:0] d);
        logic [SW-1:0] e0;
        logic [SW-1:0] e1;
        e0 = ^(r & G0) ? SMAX - d[2*SW-1:SW] : d[2*SW-1:SW];
        e1 = ^(r & G1) ? SMAX - d[SW-1:0] : d[SW-1:0];
        return {1'b0, e0} + {1'b0, e1};
    endfunction

    function automatic logic [PMW-1:0] sat_add(input logic [PMW-1:0] a, input logic [SW:0] b);
        logic [PMW:0] s;
        s = {1'b0, a} + {{(PMW - SW){1'b0}}, b};
        return s[PMW] ? '1 : s[PMW-1:0];
    endfunction

    assign i_ready   = state == RUN;
    assign accept    = i_valid && i_ready;
    assign full      = cnt == CW'(TB - 1);
    assign drain_src = P_TERM ? path_new[0] : path_new[best];

    // add-compare-select per next state; a tie keeps predecessor b=0
    always_comb begin
        for (int n = 0; n < NS; n++) begin
            cand0[n]    = sat_add(pm[pred(n, 1'b0)], branch_metric({n[K-2], pred(n, 1'b0)}, i_data));
            cand1[n]    = sat_add(pm[pred(n, 1'b1)], branch_metric({n[K-2], pred(n, 1'b1)}, i_data));
            take[n]     = cand1[n] < cand0[n];
            pm_sel[n]   = take[n] ? cand1[n] : cand0[n];
            path_new[n] = {path[pred(n, take[n])], n[K-2]};
        end
    end

    // smallest new metric and the lowest-index state holding it
    always_comb begin
        pm_min = '1;
        best   = '0;
        for (int n = 0; n < NS; n++) begin
            if (pm_sel[n] < pm_min) begin
                pm_min = pm_sel[n];
                best   = SB'(n);
            end
        end
    end

    // frame control, metric and survivor update, registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst || (state == DRAIN && dc == '0)) begin
            state      <= RUN;
            cnt        <= '0;
            dc         <= '0;
            dr         <= '0;
            o_valid    <= 1'b0;
            o_decision <= 1'b0;
            o_last     <= 1'b0;
            for (int n = 0; n < NS; n++) begin
                pm[n]   <= (n == 0) ? '0 : PM_INIT;
                path[n] <= '0;
            end
        end else if (state == DRAIN) begin
            o_valid    <= 1'b1;
            o_decision <= dr[dc - 1'b1];
            o_last     <= dc == CW'(1);
            dc         <= dc - 1'b1;
        end else begin
            o_valid <= accept && (full || i_last);
            o_last  <= accept && i_last && !full && cnt == '0;
            if (accept) begin
                o_decision <= (full || !i_last) ? path_new[best][TB-1] : drain_src[cnt];
                cnt        <= full ? cnt : cnt + 1'b1;
                dr         <= drain_src[TB-2:0];
                dc         <= full ? CW'(TB - 1) : cnt;
                state      <= i_last ? DRAIN : RUN;
                for (int n = 0; n < NS; n++) begin
                    pm[n]   <= pm_sel[n] - pm_min;
                    path[n] <= path_new[n][TB-2:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_viterbi_decoder_param.sv
// tb_viterbi_decoder_param: directed frames against hard, zero-tail and soft decoder instances
module tb_viterbi_decoder_param;
    typedef logic [5:0] frame_t [8];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] valid = '0;
    logic       last = 1'b0;
    logic [1:0] data_h = '0;
    logic [5:0] data_s = '0;
    wire  [2:0] rdy;
    wire  [2:0] ov;
    wire  [2:0] od;
    wire  [2:0] ol;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_out [3];
    int n_last [3];
    int last_idx [3];
    int low [3];
    int first_ov [3];
    logic [31:0] seq [3];

    // frames are not zero-tail terminated, so trace from the best state
    viterbi_decoder_param #(.P_TERM(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[0]), .i_data(data_h), .i_last(last),
        .i_ready(rdy[0]), .o_decision(od[0]), .o_valid(ov[0]), .o_last(ol[0])
    );
    viterbi_decoder_param dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[1]), .i_data(data_h), .i_last(last),
        .i_ready(rdy[1]), .o_decision(od[1]), .o_valid(ov[1]), .o_last(ol[1])
    );
    viterbi_decoder_param #(.SW(3), .TB(8), .P_TERM(1'b0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(valid[2]), .i_data(data_s), .i_last(last),
        .i_ready(rdy[2]), .o_decision(od[2]), .o_valid(ov[2]), .o_last(ol[2])
    );

    always #5 clk = ~clk;

    // output monitor, sampling on the falling edge
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
                if (n_out[d] == 0) first_ov[d] = cyc;
                if (ol[d]) begin
                    n_last[d]++;
                    last_idx[d] = n_out[d];
                end
                seq[d] = {seq[d][30:0], od[d]};
                n_out[d]++;
            end
            if (!rdy[d]) low[d]++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        for (int d = 0; d < 3; d++) begin
            n_out[d] = 0;
            n_last[d] = 0;
            last_idx[d] = -1;
            low[d] = 0;
            first_ov[d] = -1;
            seq[d] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int d, input logic [5:0] sym, input logic lst);
        int guard = 0;
        @(negedge clk);
        while (!rdy[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", int'(rdy[d]), 1);
        data_h = sym[1:0];
        data_s = sym;
        last = lst;
        valid[d] = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        valid = '0;
        last = 1'b0;
    endtask

    task automatic send_frame(input int d, input frame_t f, input int n);
        for (int i = 0; i < n; i++) send(d, f[i], i == n - 1);
    endtask

    task automatic check_frame(input string tag, input int d, input int n, input int bits, input int exp_low);
        check({tag, "_count"}, n_out[d], n);
        check({tag, "_bits"}, int'(seq[d]), bits);
        check({tag, "_last_count"}, n_last[d], 1);
        check({tag, "_last_pos"}, last_idx[d], n - 1);
        check({tag, "_ready_low"}, low[d], exp_low);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    frame_t f1 = '{6'd3, 6'd2, 6'd0, 6'd2, 6'd0, 6'd2, 6'd0, 6'd2};
    frame_t f2 = '{6'd0, 6'd0, 6'd3, 6'd2, 6'd0, 6'd2, 6'd3, 6'd3};
    frame_t f2e = '{6'd0, 6'd0, 6'd1, 6'd2, 6'd0, 6'd2, 6'd3, 6'd3};
    frame_t ft = '{6'd3, 6'd2, 6'd0, 6'd1, 6'd1, 6'd3, 6'd0, 6'd0};
    frame_t fs = '{6'o77, 6'o70, 6'o34, 6'o70, 6'o00, 6'o70, 6'o00, 6'o70};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t15;
        clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid%0d", d), int'(ov[d]), 0);
            check($sformatf("rst_decision%0d", d), int'(od[d]), 0);
            check($sformatf("rst_last%0d", d), int'(ol[d]), 0);
            check($sformatf("rst_ready%0d", d), int'(rdy[d]), 1);
        end

        clear();
        send_frame(0, f1, 8);
        idle(15);
        check_frame("f1", 0, 8, 'b10101010, 8);

        clear();
        send_frame(0, f2, 8);
        idle(15);
        check_frame("f2", 0, 8, 'b00101001, 8);

        clear();
        send_frame(0, f2e, 8);
        idle(15);
        check_frame("f2_err", 0, 8, 'b00101001, 8);

        clear();
        for (int i = 0; i < 7; i++) begin
            send(0, f1[i], 1'b0);
            idle(2);
        end
        check("gap_no_early_out", n_out[0], 0);
        send(0, f1[7], 1'b1);
        idle(15);
        check_frame("gap", 0, 8, 'b10101010, 8);

        clear();
        for (int i = 0; i < 4; i++) send(0, f1[i], 1'b0);
        pulse_reset();
        send_frame(0, f2, 8);
        idle(15);
        check_frame("rst_mid", 0, 8, 'b00101001, 8);

        clear();
        t15 = 0;
        for (int i = 1; i <= 20; i++) begin
            send(0, 6'd0, 1'b0);
            if (i == 15) t15 = acc_cyc;
        end
        idle(5);
        check("stream_count", n_out[0], 6);
        check("stream_bits", int'(seq[0]), 0);
        check("stream_first", first_ov[0], t15 + 1);
        check("stream_ready_low", low[0], 0);
        check("stream_no_last", n_last[0], 0);
        pulse_reset();

        clear();
        send_frame(1, ft, 6);
        idle(15);
        check_frame("term", 1, 6, 'b101100, 6);

        clear();
        send_frame(2, fs, 8);
        idle(15);
        check_frame("soft", 2, 8, 'b10101010, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
